// File: rtl/flop_share_arbiter_if.sv
// Requester-side bundle for the shared capture register arbiter.
// The arbiter takes the slave view and the requesting datapath takes the master view.
interface flop_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] data_in;
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       q;
  logic                   q_valid;
  logic [2:0]             q_owner;

  modport master (
    output req, data_in,
    input  gnt, q, q_valid, q_owner
  );

  modport slave (
    input  req, data_in,
    output gnt, q, q_valid, q_owner
  );
endinterface

// File: rtl/flop_share_arbiter.sv
// Round-robin owner of a single shared capture register.
// Grants one requester, captures its slice, then holds it valid for HOLD cycles.
module flop_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int HOLD  = 3
) (
  input logic clk,
  input logic rst,
  flop_share_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] HOLD_ST = 2'd2;

  logic [1:0]       state;
  logic [N_REQ-1:0] gnt_r;
  logic [WIDTH-1:0] q_r;
  logic             qv_r;
  logic [2:0]       own_r;
  logic [2:0]       last;
  logic [2:0]       win;
  logic [3:0]       cnt;

  logic [2:0]       pick;
  logic             pick_ok;
  logic [N_REQ-1:0] pick_oh;
  logic [WIDTH-1:0] cap;

  // Closest requester above `last`, wrapping modulo N_REQ.
  always_comb begin
    int best;
    int d;
    best = N_REQ;
    d    = 0;
    pick = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.req[i]) begin
        d = (i + 2 * N_REQ - 1 - int'(last))
          % N_REQ;
        if (d < best) begin
          best = d;
          pick = 3'(i);
        end
      end
    end
    pick_ok = |bus.req;
  end

  always_comb begin
    pick_oh = '0;
    cap     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pick_oh[i] = (pick == 3'(i));
      if (win == 3'(i))
        cap = bus.data_in[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt_r <= '0;
      q_r   <= '0;
      qv_r  <= 1'b0;
      own_r <= '0;
      last  <= 3'(N_REQ - 1);
      win   <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_ok) begin
            gnt_r <= pick_oh;
            win   <= pick;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          q_r   <= cap;
          own_r <= win;
          qv_r  <= 1'b1;
          last  <= win;
          gnt_r <= '0;
          cnt   <= 4'(HOLD - 1);
          state <= HOLD_ST;
        end
        HOLD_ST: begin
          // Last hold cycle doubles as the IDLE
          // sample so grants repeat every HOLD+1.
          if (cnt == 4'd0) begin
            qv_r <= 1'b0;
            if (pick_ok) begin
              gnt_r <= pick_oh;
              win   <= pick;
              state <= CAPTURE;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.q       = q_r;
  assign bus.q_valid = qv_r;
  assign bus.q_owner = own_r;

endmodule

// File: tb/tb_flop_share_arbiter.sv
// Directed vector bench for flop_share_arbiter.
// Cycle table plus hand sequences for drop, reset and hold cases.
module tb_flop_share_arbiter;

  logic clk;
  logic rst;

  flop_share_arbiter_if #(
    .N_REQ(4),
    .WIDTH(8)
  ) bus ();

  flop_share_arbiter #(
    .N_REQ(4),
    .WIDTH(8),
    .HOLD (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        qv;
    logic [2:0]  own;
  } vec_t;

  vec_t tbl[$];
  int   nvec;
  int   nbad;

  localparam logic [31:0] DA5 = 32'h13A5_1110;
  localparam logic [31:0] DRR = 32'h1312_1110;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string      nm,
    input logic [3:0] eg,
    input logic [7:0] eq,
    input logic       ev,
    input logic [2:0] eo
  );
    nvec++;
    if (bus.gnt !== eg || bus.q !== eq ||
        bus.q_valid !== ev ||
        bus.q_owner !== eo) begin
      nbad++;
      $display(
        "FAIL %s: got gnt=%b q=%h v=%b own=%0d want gnt=%b q=%h v=%b own=%0d",
        nm, bus.gnt, bus.q, bus.q_valid,
        bus.q_owner, eg, eq, ev, eo);
    end
  endtask

  task automatic add(
    input logic r, input logic [3:0] rq,
    input logic [31:0] d,
    input logic [3:0] g, input logic [7:0] q,
    input logic v, input logic [2:0] o
  );
    vec_t t;
    t.rst = r; t.req = rq; t.din = d;
    t.gnt = g; t.q = q; t.qv = v; t.own = o;
    tbl.push_back(t);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    nvec = 0;
    nbad = 0;
    rst = 1'b1;
    bus.req = '0;
    bus.data_in = '0;

    // single requester, then drop after re-grant
    add(0, 4'b0100, DA5, 4'b0100, 8'h00, 0, 0);
    add(0, 4'b0100, DA5, 4'b0000, 8'hA5, 1, 2);
    add(0, 4'b0100, DA5, 4'b0000, 8'hA5, 1, 2);
    add(0, 4'b0100, DA5, 4'b0000, 8'hA5, 1, 2);
    add(0, 4'b0100, DA5, 4'b0100, 8'hA5, 0, 2);
    add(0, 4'b0000, DA5, 4'b0000, 8'hA5, 1, 2);
    add(0, 4'b0000, DA5, 4'b0000, 8'hA5, 1, 2);
    add(0, 4'b0000, DA5, 4'b0000, 8'hA5, 1, 2);
    add(0, 4'b0000, DA5, 4'b0000, 8'hA5, 0, 2);
    add(0, 4'b0000, DA5, 4'b0000, 8'hA5, 0, 2);
    // reset, then round-robin over all four
    add(1, 4'b1111, DRR, 4'b0000, 8'h00, 0, 0);
    add(0, 4'b1111, DRR, 4'b0001, 8'h00, 0, 0);
    add(0, 4'b1111, DRR, 4'b0000, 8'h10, 1, 0);
    add(0, 4'b1111, DRR, 4'b0000, 8'h10, 1, 0);
    add(0, 4'b1111, DRR, 4'b0000, 8'h10, 1, 0);
    add(0, 4'b1111, DRR, 4'b0010, 8'h10, 0, 0);
    add(0, 4'b1111, DRR, 4'b0000, 8'h11, 1, 1);
    add(0, 4'b1111, DRR, 4'b0000, 8'h11, 1, 1);
    add(0, 4'b1111, DRR, 4'b0000, 8'h11, 1, 1);
    add(0, 4'b1111, DRR, 4'b0100, 8'h11, 0, 1);
    add(0, 4'b1111, DRR, 4'b0000, 8'h12, 1, 2);
    add(0, 4'b1111, DRR, 4'b0000, 8'h12, 1, 2);
    add(0, 4'b1111, DRR, 4'b0000, 8'h12, 1, 2);
    add(0, 4'b1111, DRR, 4'b1000, 8'h12, 0, 2);
    add(0, 4'b1111, DRR, 4'b0000, 8'h13, 1, 3);
    add(0, 4'b1111, DRR, 4'b0000, 8'h13, 1, 3);
    add(0, 4'b1111, DRR, 4'b0000, 8'h13, 1, 3);
    add(0, 4'b1111, DRR, 4'b0001, 8'h13, 0, 3);
    add(0, 4'b1111, DRR, 4'b0000, 8'h10, 1, 0);

    #1;
    check("rst_async", 4'b0, 8'h00, 0, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_dflt", 4'b0, 8'h00, 0, 0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst;
      bus.req = tbl[i].req;
      bus.data_in = tbl[i].din;
      step();
      check($sformatf("tbl%0d", i), tbl[i].gnt,
        tbl[i].q, tbl[i].qv, tbl[i].own);
    end

    // req[1] only seen for the IDLE sample
    do_reset();
    bus.data_in = 32'h0000_5A00;
    bus.req = 4'b0010;
    step();
    check("drop_gnt", 4'b0010, 8'h00, 0, 0);
    bus.req = 4'b0000;
    step();
    check("drop_cap", 4'b0000, 8'h5A, 1, 1);
    step();
    check("drop_h1", 4'b0000, 8'h5A, 1, 1);
    step();
    check("drop_h2", 4'b0000, 8'h5A, 1, 1);
    step();
    check("drop_end", 4'b0000, 8'h5A, 0, 1);

    // asynchronous reset in the middle of a hold
    do_reset();
    bus.data_in = 32'hB800_0077;
    bus.req = 4'b0001;
    step();
    check("mh_gnt", 4'b0001, 8'h00, 0, 0);
    bus.req = 4'b0000;
    step();
    check("mh_cap", 4'b0000, 8'h77, 1, 0);
    #2 rst = 1'b1;
    #1;
    check("mh_async", 4'b0000, 8'h00, 0, 0);
    step();
    rst = 1'b0;
    bus.req = 4'b1000;
    step();
    check("mh_gnt3", 4'b1000, 8'h00, 0, 0);
    bus.req = 4'b1001;
    step();
    check("mh_cap3", 4'b0000, 8'hB8, 1, 3);
    step();
    step();
    check("mh_h2", 4'b0000, 8'hB8, 1, 3);
    step();
    check("mh_wrap0", 4'b0001, 8'hB8, 0, 3);

    // req[3] arrives while req[0] holds
    do_reset();
    bus.data_in = 32'h2400_0021;
    bus.req = 4'b0001;
    step();
    check("hr_gnt0", 4'b0001, 8'h00, 0, 0);
    step();
    check("hr_cap0", 4'b0000, 8'h21, 1, 0);
    bus.req = 4'b1001;
    step();
    check("hr_hold1", 4'b0000, 8'h21, 1, 0);
    step();
    check("hr_hold2", 4'b0000, 8'h21, 1, 0);
    step();
    check("hr_gnt3", 4'b1000, 8'h21, 0, 0);
    step();
    check("hr_cap3", 4'b0000, 8'h24, 1, 3);

    $display("== %0d vectors applied, %0d miscompares ==",
      nvec, nbad);
    $finish;
  end

endmodule
